// File: rtl/srt4_pkg.sv
// Shared encodings for the radix-4 engines.
// Covers the FSM states and the sign-magnitude Booth/quotient digits.
package srt4_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    D0  = 3'b000,
    DP1 = 3'b001,
    DP2 = 3'b010,
    DN1 = 3'b101,
    DN2 = 3'b110
  } digit_t;

endpackage

// File: rtl/booth4_multiplier_if.sv
// Host operand bus for the Booth multiplier.
// Uses the same begin/end handshake as the SRT-4 divider.
interface booth4_multiplier_if #(
  parameter int WIDTH = 8
);

  logic               beginSignal;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               endSignal;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output beginSignal, x, y,
    input  busy, endSignal, prod
  );

  modport slave (
    input  beginSignal, x, y,
    output busy, endSignal, prod
  );

endinterface

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: {Q1,Q0,Q_1} -> digit.
// Mirrors the divider's quotient-selection table.
module booth4_recoder
  import srt4_pkg::*;
(
  input  logic [2:0] bits,
  output digit_t     digit
);

  always_comb begin
    digit = D0;
    unique case (bits)
      3'b001, 3'b010: digit = DP1;
      3'b011:         digit = DP2;
      3'b100:         digit = DN2;
      3'b101, 3'b110: digit = DN1;
      default:        digit = D0;
    endcase
  end

endmodule

// File: rtl/booth4_multiplier.sv
// Sequential signed radix-4 Booth multiplier.
// Fixed latency: one digit per ADD/SHIFT pair.
module booth4_multiplier
  import srt4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_b,
  booth4_multiplier_if.slave bus
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;

  state_t             state;
  state_t             state_nx;
  logic [AW-1:0]      a;
  logic [WIDTH-1:0]   q;
  logic               q_1;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      a_sum;
  logic [AW-1:0]      a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               last;
  logic               busy;
  logic               end_sig;
  digit_t             digit;

  booth4_recoder u_recoder (
    .bits  ({q[1:0], q_1}),
    .digit (digit)
  );

  assign m_ext = {{2{m[WIDTH-1]}}, m};
  assign a_sum = a + addend;
  assign a_sh  = {{2{a[AW-1]}}, a[AW-1:2]};
  assign q_sh  = {a[1:0], q[WIDTH-1:2]};
  assign last  = (cnt == CW'(WIDTH / 2 - 1));

  always_comb begin
    addend = '0;
    unique case (digit)
      DP1:     addend = m_ext;
      DP2:     addend = m_ext << 1;
      DN1:     addend = -m_ext;
      DN2:     addend = -(m_ext << 1);
      default: addend = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.beginSignal) state_nx = LOAD;
      LOAD:    state_nx = ADD;
      ADD:     state_nx = SHIFT;
      SHIFT:   state_nx = last ? DONE : ADD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    end_sig = (state == DONE);
  end

  // prod is captured on entry to DONE so it is valid alongside endSignal
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a    <= '0;
      q    <= '0;
      q_1  <= 1'b0;
      m    <= '0;
      cnt  <= '0;
      prod <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.beginSignal) begin
          m   <= bus.x;
          q   <= bus.y;
          a   <= '0;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        ADD: a <= a_sum;
        SHIFT: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[1];
          cnt <= cnt + CW'(1);
          if (last) prod <= {a_sh[WIDTH-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.endSignal = end_sig;
  assign bus.prod      = prod;

endmodule
